cnn_argmax_classifier: RTL and testbench

Output stage of the CNN, directly downstream of the fully connected layer. Accepts one vector of `num_classes` signed scores (one per dense neuron) through a valid/ready handshake, scans it serially one score per clock, and returns:
- the winning class index,
- the maximum score,
- the margin between the best and second-best scores.

The result is held until a downstream consumer acknowledges it.

---
 rtl/cnn_argmax_classifier_pkg.sv | 24 ++
 rtl/argmax_update.sv | 55 +++++
 rtl/cnn_argmax_classifier.sv | 215 +++++++++++++++++++++
 tb/tb_cnn_argmax_classifier.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_argmax_classifier_pkg.sv
// ---------------------------------------------------------------------------
// cnn_pkg
// Shared definitions for the CNN output stage.
//   CNN_DATA_WIDTH  : default score width (signed two's complement)
//   CNN_NUM_CLASSES : default number of scores per vector
//   CNN_SCORE_MIN   : most negative score at the default width; used as the
//                     starting value of the second-best tracker
//   argmax_state_t  : controller states of the argmax classifier
// ---------------------------------------------------------------------------
package cnn_pkg;

    localparam int CNN_DATA_WIDTH  = 32;
    localparam int CNN_NUM_CLASSES = 10;

    localparam logic [CNN_DATA_WIDTH-1:0] CNN_SCORE_MIN =
        {1'b1, {(CNN_DATA_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        HOLD = 2'd2
    } argmax_state_t;

endpackage

// File: rtl/argmax_update.sv
// ---------------------------------------------------------------------------
// argmax_update
// One step of the running best / second-best search. Purely combinational.
// A score only displaces the current best when it is strictly greater, so an
// earlier index keeps the win on ties and the equal later score drops into
// the second-best slot instead.
//
// Ports:
//   i_s       : candidate score (signed)
//   i_best    : current best score (signed)
//   i_second  : current second-best score (signed)
//   i_idx     : index of the current best
//   i_cnt     : index of the candidate
//   o_best    : updated best score
//   o_second  : updated second-best score
//   o_idx     : updated best index
// ---------------------------------------------------------------------------
module argmax_update
    import cnn_pkg::*;
#(
    parameter int data_width = CNN_DATA_WIDTH,
    parameter int idx_width  = $clog2(CNN_NUM_CLASSES)
) (
    input  logic [data_width-1:0] i_s,
    input  logic [data_width-1:0] i_best,
    input  logic [data_width-1:0] i_second,
    input  logic [idx_width-1:0]  i_idx,
    input  logic [idx_width-1:0]  i_cnt,
    output logic [data_width-1:0] o_best,
    output logic [data_width-1:0] o_second,
    output logic [idx_width-1:0]  o_idx
);

    logic w_gt_best;
    logic w_gt_second;

    assign w_gt_best   = $signed(i_s) > $signed(i_best);
    assign w_gt_second = $signed(i_s) > $signed(i_second);

    always_comb begin
        o_best   = i_best;
        o_second = i_second;
        o_idx    = i_idx;
        if (w_gt_best) begin
            // The old best is by construction >= old second, so it becomes
            // the new second.
            o_second = i_best;
            o_best   = i_s;
            o_idx    = i_cnt;
        end else if (w_gt_second) begin
            o_second = i_s;
        end
    end

endmodule

// File: rtl/cnn_argmax_classifier.sv
// ---------------------------------------------------------------------------
// cnn_argmax_classifier
// Output stage of the CNN. Accepts a vector of num_classes signed scores,
// scans it one score per clock and returns the winning class, the maximum
// score and the margin to the second-best score. The result is held until
// the consumer takes it.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. The producer must hold valid and data until that edge; ready
// carries no obligation and may depend on state only (never on valid).
//
// Ports:
//   clk        : clock, rising edge
//   rstb       : asynchronous active-low reset
//   in_valid   : score vector present on scores
//   in_ready   : block can accept a vector (high only in IDLE)
//   scores     : flattened scores, class i at [i*data_width +: data_width]
//   out_valid  : result valid (high only in HOLD)
//   out_ready  : consumer accepts the result
//   class_idx  : index of the maximum score (lowest index on ties)
//   max_score  : maximum score, signed
//   margin     : max_score - second_score, unsigned, data_width+1 bits
//   dbg_state  : current controller state (argmax_state_t encoding)
// ---------------------------------------------------------------------------
module cnn_argmax_classifier
    import cnn_pkg::*;
#(
    parameter int num_classes = CNN_NUM_CLASSES,
    parameter int data_width  = CNN_DATA_WIDTH,
    parameter int idx_width   = $clog2(num_classes)
) (
    input  logic                              clk,
    input  logic                              rstb,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [data_width*num_classes-1:0] scores,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [idx_width-1:0]              class_idx,
    output logic [data_width-1:0]             max_score,
    output logic [data_width:0]               margin,
    output logic [1:0]                        dbg_state
);

    localparam logic [idx_width-1:0]  LAST_IDX  = idx_width'(num_classes - 1);
    localparam logic [data_width-1:0] SCORE_MIN = {1'b1, {(data_width-1){1'b0}}};

    // -----------------------------------------------------------------------
    // State and datapath registers
    // -----------------------------------------------------------------------
    argmax_state_t         r_state;
    argmax_state_t         w_next_state;

    logic [data_width-1:0] r_scores [num_classes];
    logic [idx_width-1:0]  r_cnt;
    logic [data_width-1:0] r_best;
    logic [data_width-1:0] r_second;
    logic [idx_width-1:0]  r_idx;

    logic [idx_width-1:0]  r_class_idx;
    logic [data_width-1:0] r_max_score;
    logic [data_width:0]   r_margin;

    logic                  w_accept;
    logic                  w_release;
    logic                  w_last;
    logic [data_width-1:0] w_s;
    logic [data_width-1:0] w_upd_best;
    logic [data_width-1:0] w_upd_second;
    logic [idx_width-1:0]  w_upd_idx;
    logic [data_width:0]   w_best_ext;
    logic [data_width:0]   w_second_ext;
    logic [data_width:0]   w_margin;

    assign w_accept  = in_valid  && (r_state == IDLE);
    assign w_release = out_ready && (r_state == HOLD);
    assign w_last    = (r_cnt == LAST_IDX);
    assign w_s       = r_scores[r_cnt];

    // -----------------------------------------------------------------------
    // Compare / update step
    // -----------------------------------------------------------------------
    argmax_update #(
        .data_width (data_width),
        .idx_width  (idx_width)
    ) u_update (
        .i_s      (w_s),
        .i_best   (r_best),
        .i_second (r_second),
        .i_idx    (r_idx),
        .i_cnt    (r_cnt),
        .o_best   (w_upd_best),
        .o_second (w_upd_second),
        .o_idx    (w_upd_idx)
    );

    // Sign-extend both operands by one bit so the difference of any two
    // signed scores is representable and always non-negative here.
    assign w_best_ext   = {w_upd_best[data_width-1], w_upd_best};
    assign w_second_ext = {w_upd_second[data_width-1], w_upd_second};
    assign w_margin     = w_best_ext - w_second_ext;

    // -----------------------------------------------------------------------
    // FSM: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // -----------------------------------------------------------------------
    // FSM: next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_next_state = SCAN;
                end
            end
            SCAN: begin
                if (w_last) begin
                    w_next_state = HOLD;
                end
            end
            HOLD: begin
                if (w_release) begin
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // FSM: outputs (decoded from the state register only)
    // -----------------------------------------------------------------------
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (r_state)
            IDLE:    in_ready  = 1'b1;
            SCAN:    in_ready  = 1'b0;
            HOLD:    out_valid = 1'b1;
            default: in_ready  = 1'b0;
        endcase
    end

    assign dbg_state = r_state;

    // -----------------------------------------------------------------------
    // Capture bank: loaded only on the accept edge
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            for (int i = 0; i < num_classes; i++) begin
                r_scores[i] <= '0;
            end
        end else if (w_accept) begin
            for (int i = 0; i < num_classes; i++) begin
                r_scores[i] <= scores[i*data_width +: data_width];
            end
        end
    end

    // -----------------------------------------------------------------------
    // Scan counter and running best / second / index
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_cnt    <= '0;
            r_best   <= '0;
            r_second <= '0;
            r_idx    <= '0;
        end else if (w_accept) begin
            // Score 0 seeds the best directly, so the scan starts at index 1.
            r_cnt    <= idx_width'(1);
            r_best   <= scores[data_width-1:0];
            r_second <= SCORE_MIN;
            r_idx    <= '0;
        end else if (r_state == SCAN) begin
            r_cnt    <= w_last ? '0 : r_cnt + idx_width'(1);
            r_best   <= w_upd_best;
            r_second <= w_upd_second;
            r_idx    <= w_upd_idx;
        end
    end

    // -----------------------------------------------------------------------
    // Result registers: loaded from the final update step so they are already
    // stable in the first HOLD cycle and stay untouched until the next scan.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_class_idx <= '0;
            r_max_score <= '0;
            r_margin    <= '0;
        end else if ((r_state == SCAN) && w_last) begin
            r_class_idx <= w_upd_idx;
            r_max_score <= w_upd_best;
            r_margin    <= w_margin;
        end
    end

    assign class_idx = r_class_idx;
    assign max_score = r_max_score;
    assign margin    = r_margin;

endmodule

// File: tb/tb_cnn_argmax_classifier.sv
// ---------------------------------------------------------------------------
// tb_cnn_argmax_classifier
// Directed and streaming checks of cnn_argmax_classifier at default
// parameters (10 classes, 32-bit scores).
// ---------------------------------------------------------------------------
module tb_cnn_argmax_classifier;

    localparam int NC = 10;
    localparam int DW = 32;
    localparam int IW = 4;
    localparam int RW = IW + DW + DW + 1;

    // -----------------------------------------------------------------------
    // Clock / reset
    // -----------------------------------------------------------------------
    logic clk  = 1'b0;
    logic rstb = 1'b0;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // -----------------------------------------------------------------------
    // DUT
    // -----------------------------------------------------------------------
    logic               in_valid  = 1'b0;
    logic               in_ready;
    logic [DW*NC-1:0]   scores    = '0;
    logic               out_valid;
    logic               out_ready = 1'b0;
    logic [IW-1:0]      class_idx;
    logic [DW-1:0]      max_score;
    logic [DW:0]        margin;
    logic [1:0]         dbg_state;

    cnn_argmax_classifier #(
        .num_classes (NC),
        .data_width  (DW),
        .idx_width   (IW)
    ) dut (
        .clk       (clk),
        .rstb      (rstb),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .scores    (scores),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .class_idx (class_idx),
        .max_score (max_score),
        .margin    (margin),
        .dbg_state (dbg_state)
    );

    // -----------------------------------------------------------------------
    // Checking
    // -----------------------------------------------------------------------
    int tests_run    = 0;
    int tests_failed = 0;

    task automatic check_val(input string tag, input logic [127:0] obs,
                             input logic [127:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // -----------------------------------------------------------------------
    // Reference model: first-occurrence argmax, second = max over all other
    // positions, margin computed in 33-bit signed arithmetic.
    // -----------------------------------------------------------------------
    function automatic logic [RW-1:0] model(input logic [DW*NC-1:0] flat);
        logic signed [DW-1:0] v [NC];
        logic signed [DW-1:0] sc;
        logic signed [DW:0]   a;
        logic signed [DW:0]   b;
        logic signed [DW:0]   m;
        int                   bi;
        bit                   first;
        for (int i = 0; i < NC; i++) v[i] = flat[i*DW +: DW];
        bi = 0;
        for (int i = 1; i < NC; i++) if (v[i] > v[bi]) bi = i;
        first = 1'b1;
        sc    = '0;
        for (int i = 0; i < NC; i++) begin
            if (i != bi && (first || v[i] > sc)) begin
                sc    = v[i];
                first = 1'b0;
            end
        end
        a = v[bi];
        b = sc;
        m = a - b;
        return {IW'(bi), v[bi], m};
    endfunction

    // -----------------------------------------------------------------------
    // Scoreboard: expected results queued on accept, compared on release
    // -----------------------------------------------------------------------
    logic [RW-1:0] exp_q [$];
    int            n_results = 0;

    always @(negedge clk) begin
        if (rstb) begin
            if (in_valid && in_ready) exp_q.push_back(model(scores));
            if (out_valid && out_ready) begin
                check_val("sb_nonempty", 128'(exp_q.size() != 0), 128'(1));
                if (exp_q.size() != 0) begin
                    check_val("sb_result", 128'({class_idx, max_score, margin}),
                              128'(exp_q.pop_front()));
                end
                n_results++;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Driver tasks
    // -----------------------------------------------------------------------
    logic [DW-1:0] vec [NC];
    int            acc_cyc = 0;

    task automatic load_scores();
        for (int i = 0; i < NC; i++) scores[i*DW +: DW] = vec[i];
    endtask

    // Presents vec and returns #1 after the accept edge with in_valid low.
    task automatic send_vec();
        int n = 0;
        @(posedge clk); #1;
        load_scores();
        in_valid = 1'b1;
        while (!in_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check_val("accept_ready", 128'(in_ready), 128'(1));
        @(posedge clk); #1;
        acc_cyc  = cyc;
        in_valid = 1'b0;
    endtask

    task automatic wait_result(output int lat);
        int n = 0;
        while (!out_valid && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check_val("result_valid", 128'(out_valid), 128'(1));
        lat = cyc - acc_cyc;
    endtask

    task automatic take_result();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic check_result(input string tag, input logic [IW-1:0] e_idx,
                                input logic [DW-1:0] e_max, input logic [DW:0] e_mrg);
        check_val({tag, "_idx"},    128'(class_idx), 128'(e_idx));
        check_val({tag, "_max"},    128'(max_score), 128'(e_max));
        check_val({tag, "_margin"}, 128'(margin),    128'(e_mrg));
    endtask

    task automatic set_distinct();
        for (int i = 0; i < NC; i++) vec[i] = DW'(i * 10 - 50);
        vec[7] = 32'd1000;
    endtask

    task automatic gen_random();
        int mode;
        int t;
        mode = int'($urandom_range(0, 2));
        for (int i = 0; i < NC; i++) begin
            case (mode)
                0: vec[i] = $urandom;
                1: begin
                    t      = int'($urandom_range(0, 6)) - 3;
                    vec[i] = DW'(t);
                end
                default: begin
                    case ($urandom_range(0, 3))
                        0: vec[i] = 32'h7FFF_FFFF;
                        1: vec[i] = 32'h8000_0000;
                        2: vec[i] = 32'h0000_0000;
                        default: vec[i] = 32'hFFFF_FFFF;
                    endcase
                end
            endcase
        end
    endtask

    // -----------------------------------------------------------------------
    // Stimulus
    // -----------------------------------------------------------------------
    initial begin
        int lat;
        int base;
        int guard;
        logic [IW-1:0] h_idx;
        logic [DW-1:0] h_max;
        logic [DW:0]   h_mrg;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_in_ready",  128'(in_ready),  128'(1));
        check_val("rst_out_valid", 128'(out_valid), 128'(0));
        check_val("rst_state",     128'(dbg_state), 128'(0));
        check_result("rst", '0, '0, '0);
        rstb = 1'b1;

        // Distinct scores
        set_distinct();
        send_vec();
        check_val("t1_in_ready_scan", 128'(in_ready), 128'(0));
        wait_result(lat);
        check_val("t1_latency", 128'(lat), 128'(9));
        check_result("t1", 4'd7, 32'd1000, 33'd960);
        check_val("t1_in_ready_hold", 128'(in_ready), 128'(0));
        take_result();
        check_val("t1_in_ready_after", 128'(in_ready), 128'(1));
        check_val("t1_out_valid_after", 128'(out_valid), 128'(0));

        // All negative with a tie at 3 and 8; then changed scores during the
        // scan plus 20 cycles of back-pressure.
        for (int i = 0; i < NC; i++) vec[i] = 32'hFFFF_FFFB;
        vec[3] = 32'hFFFF_FFFF;
        vec[8] = 32'hFFFF_FFFF;
        send_vec();
        for (int i = 0; i < NC; i++) vec[i] = 32'h8000_0000;
        vec[0] = 32'h7FFF_FFFF;
        load_scores();
        in_valid = 1'b1;
        wait_result(lat);
        check_val("t2_latency", 128'(lat), 128'(9));
        check_result("t2", 4'd3, 32'hFFFF_FFFF, 33'd0);
        h_idx = class_idx;
        h_max = max_score;
        h_mrg = margin;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            check_val("bp_out_valid", 128'(out_valid), 128'(1));
            check_val("bp_in_ready",  128'(in_ready),  128'(0));
            check_val("bp_stable", 128'({class_idx, max_score, margin}),
                      128'({h_idx, h_max, h_mrg}));
        end
        take_result();
        check_val("bp_idle_ready", 128'(in_ready), 128'(1));
        @(posedge clk); #1;
        acc_cyc  = cyc;
        in_valid = 1'b0;
        check_val("bp_pending_accepted", 128'(dbg_state), 128'(1));

        // Extremes (the pending vector)
        wait_result(lat);
        check_val("t3_latency", 128'(lat), 128'(9));
        check_result("t3", 4'd0, 32'h7FFF_FFFF, 33'h0_FFFF_FFFF);
        take_result();

        // Reset during SCAN
        for (int i = 0; i < NC; i++) vec[i] = DW'(i);
        send_vec();
        repeat (4) @(posedge clk);
        #1;
        rstb = 1'b0;
        #1;
        check_val("rs_out_valid", 128'(out_valid), 128'(0));
        check_val("rs_in_ready",  128'(in_ready),  128'(1));
        check_result("rs", '0, '0, '0);
        exp_q.delete();
        @(posedge clk); #1;
        rstb = 1'b1;
        set_distinct();
        send_vec();
        wait_result(lat);
        check_val("rs_next_latency", 128'(lat), 128'(9));
        check_result("rs_next", 4'd7, 32'd1000, 33'd960);
        take_result();

        // Streaming: random vectors, random gaps, random out_ready
        base  = n_results;
        guard = 0;
        fork
            begin
                for (int n = 0; n < 100; n++) begin
                    repeat ($urandom_range(0, 3)) @(posedge clk);
                    gen_random();
                    send_vec();
                end
            end
            begin
                while (n_results < base + 100 && guard < 20000) begin
                    @(posedge clk); #1;
                    out_ready = 1'($urandom_range(0, 1));
                    guard++;
                end
                out_ready = 1'b0;
            end
        join
        check_val("stream_count", 128'(n_results - base), 128'(100));
        check_val("stream_queue_empty", 128'(exp_q.size()), 128'(0));

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
